axis_mux_arb: RTL

- Control stage directly upstream of the S_COUNT-input AXI-stream mux. It drives the mux's enable and select inputs.
- Watches per-source tvalid request lines and the mux output handshake. Grants one source at a time for exactly one frame, using round-robin fairness.
- Also reports per-frame beat count and completion for statistics and debug.

---
 rtl/axis_mux_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axis_mux_arb.sv
// axis_mux_arb: frame-granular arbiter driving the enable/select inputs of an
// S_COUNT-input AXI-stream mux. One source is granted per frame, with a
// mandatory one-cycle enable gap between frames, and each completed frame's
// beat count is reported.
// Build option: define AXIS_MUX_ARB_PRIORITY_EN for fixed lowest-index-wins
// priority; leave it undefined for round-robin arbitration.
module axis_mux_arb #(
    parameter int unsigned S_COUNT      = 4,
    parameter int unsigned SELECT_WIDTH = $clog2(S_COUNT),
    parameter int unsigned LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [S_COUNT-1:0]      s_axis_tvalid,
    input  logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic                    m_axis_tlast,
    output logic                    enable,
    output logic [SELECT_WIDTH-1:0] select,
    output logic                    busy,
    output logic                    frame_done,
    output logic [LEN_WIDTH-1:0]    frame_len
);

    localparam logic [LEN_WIDTH-1:0]    LEN_MAX  = {LEN_WIDTH{1'b1}};
    localparam logic [SELECT_WIDTH-1:0] SEL_LAST = SELECT_WIDTH'(S_COUNT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    enable_d, busy_d, frame_done_d;
    logic [SELECT_WIDTH-1:0] select_d;
    logic [LEN_WIDTH-1:0]    frame_len_d;
    logic                    beat_c, last_c, req_any_c;
    logic [SELECT_WIDTH-1:0] winner_c;

    assign beat_c    = m_axis_tvalid & m_axis_tready;
    assign last_c    = beat_c & m_axis_tlast;
    assign req_any_c = |s_axis_tvalid;

`ifdef AXIS_MUX_ARB_PRIORITY_EN
    // Fixed priority: lowest set request index wins.
    always_comb begin
        winner_c = '0;
        for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) winner_c = SELECT_WIDTH'(i);
        end
    end
`else
    logic [SELECT_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [SELECT_WIDTH-1:0] rr_cand_c;
    logic                    rr_found_c;

    // Round-robin: first set request searching upward from last_grant+1, wrapping at S_COUNT.
    always_comb begin
        winner_c   = '0;
        rr_found_c = 1'b0;
        rr_cand_c  = last_grant_q;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            rr_cand_c = (rr_cand_c == SEL_LAST) ? '0 : rr_cand_c + SELECT_WIDTH'(1);
            if (!rr_found_c && s_axis_tvalid[rr_cand_c]) begin
                winner_c   = rr_cand_c;
                rr_found_c = 1'b1;
            end
        end
    end
`endif

    // Next-state and next-output logic; grants only from IDLE, releases on last beat.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enable_d     = enable;
        select_d     = select;
        busy_d       = busy;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len;
`ifndef AXIS_MUX_ARB_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_en && req_any_c) begin
                    select_d = winner_c;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (last_c) begin
                    enable_d     = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    frame_len_d  = (cnt_q == LEN_MAX) ? LEN_MAX : cnt_q + LEN_WIDTH'(1);
                    state_d      = IDLE;
`ifndef AXIS_MUX_ARB_PRIORITY_EN
                    last_grant_d = select;
`endif
                end else if (beat_c && (cnt_q != LEN_MAX)) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            enable       <= 1'b0;
            select       <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_len    <= '0;
`ifndef AXIS_MUX_ARB_PRIORITY_EN
            last_grant_q <= SEL_LAST;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enable       <= enable_d;
            select       <= select_d;
            busy         <= busy_d;
            frame_done   <= frame_done_d;
            frame_len    <= frame_len_d;
`ifndef AXIS_MUX_ARB_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule
